nios2_system_gpio_pio: RTL
==========================

Name: nios2_system_gpio_pio

Overview:
- Parametrised Avalon-MM general-purpose I/O peripheral for the Nios II system; successor to the fixed 8-bit output-only PIO.
- Adds per-bit direction control, atomic set and clear of output bits, synchronised inputs, and edge capture with a maskable interrupt.
- Sits on the system interconnect as one slave with a registered, latency-1 read path.
- Feeds the game-board LEDs and buttons and the radio-module handshake lines.

Parameters:
- DATA_WIDTH, 8, number of GPIO bits (1..32).
- RESET_VALUE, 0, reset value of data_out (DATA_WIDTH bits).
- EDGE_TYPE, 0, edge captured: 0 rising, 1 falling, 2 any.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset  input  1  asynchronous, active-high reset.
- address  input  3  register word select.
- chipselect  input  1  slave select.
- read_n  input  1  active-low read strobe.
- write_n  input  1  active-low write strobe.
- writedata  input  32  write data; bits above DATA_WIDTH are ignored.
- readdata  output  32  registered read data, zero-extended.
- in_port  input  DATA_WIDTH  asynchronous pin inputs.
- out_port  output  DATA_WIDTH  output value (data_out).
- out_oe  output  DATA_WIDTH  per-bit output enable (direction register).
- irq  output  1  interrupt request, active-high.

Behaviour:
- Register map (wr = chipselect & ~write_n; rd = chipselect & ~read_n):
  - 0 DATA: write loads data_out. Read returns (data_out & dir) | (in_sync & ~dir).
  - 1 DIRECTION: read/write; 1 = output.
  - 2 IRQMASK: read/write.
  - 3 EDGECAPTURE: read returns the capture register; writing 1 to a bit clears it.
  - 4 OUTSET: write ORs writedata into data_out; reads return 0.
  - 5 OUTCLEAR: write clears data_out bits where writedata = 1; reads return 0.
  - 6, 7: writes are ignored; reads return 0.
- Reset (asynchronous on reset = 1):
  - data_out = RESET_VALUE; dir = 0; mask = 0; edgecapture = 0.
  - sync1, sync2 and prev = 0; readdata = 0; warm-up counter = 0.
  - Resulting outputs: out_port = RESET_VALUE, out_oe = 0, irq = 0.
  - Reset mid-operation aborts any pending read; readdata is forced to 0.
- Write timing: a register write takes effect at the clock edge where wr is sampled; out_port and out_oe change at that same edge.
- Read timing:
  - readdata is loaded at the edge where rd is sampled and is valid the following cycle.
  - readdata holds its value when rd = 0.
  - rd and wr asserted in the same cycle: the read returns the pre-write value.
- Input path:
  - in_port passes through a 2-flop synchroniser (sync1, sync2); in_sync = sync2.
  - prev is loaded with sync2 every cycle.
- Edge detect:
  - rising = sync2 & ~prev; falling = ~sync2 & prev; any = sync2 ^ prev.
  - Selected by EDGE_TYPE. Edges are detected on all bits regardless of direction.
- Latency: an in_port change sampled at edge N sets its edgecapture bit at edge N+2.
- Warm-up: a 2-bit counter saturates at 3 after reset. Edge detection is suppressed until the counter reaches 3, so no spurious capture occurs when pins are high at reset release.
- Edge capture:
  - edgecapture bits are sticky.
  - A clear-write and a new edge on the same bit in the same cycle: the edge wins and the bit stays 1.
  - Clear-writes to other bits do not disturb set bits.
- Interrupt: irq = |(edgecapture & mask), combinational from registers (glitch-free).
  - Masking a set bit deasserts irq in the cycle after the mask write.
- Width rule: registers are DATA_WIDTH wide. All reads zero-extend to 32 bits; writedata[31:DATA_WIDTH] is ignored.

Test Plan:
- Reset, DATA_WIDTH=8, RESET_VALUE=8'hA5 -> out_port=8'hA5, out_oe=0, irq=0; read address 3 returns 0.
- Write DIRECTION=8'h0F, DATA=8'h3C; then OUTSET 8'h81, OUTCLEAR 8'h04 -> out_port=8'hB9, out_oe=8'h0F. With in_port=8'h50, read DATA one cycle later returns 8'h59.
- EDGE_TYPE=0, mask=8'h02; in_port bit1 0->1 at edge N -> edgecapture=8'h02 at N+2, irq=1. Write 8'h02 to address 3 -> irq=0 the next cycle.
- Clear-write of bit1 in the same cycle a new rising edge on bit1 is detected -> edgecapture bit1 remains 1, irq stays 1.
- in_port=8'hFF held through reset release -> edgecapture stays 0 for 10 cycles, irq=0. Then bit7 1->0 with EDGE_TYPE=1 -> edgecapture=8'h80.
- Assert reset during a read cycle -> readdata=0 immediately (asynchronous); all registers return to reset values.

Source files
------------

// File: rtl/nios2_system_gpio_pio_if.sv
// Avalon-MM slave bus bundle for the GPIO PIO.
//   address    : register word select
//   chipselect : slave select
//   read_n     : active-low read strobe
//   write_n    : active-low write strobe
//   writedata  : write data
//   readdata   : registered read data, valid the cycle after the read strobe
interface nios2_system_gpio_pio_if;
  logic [2:0]  address;
  logic        chipselect;
  logic        read_n;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output address, chipselect, read_n, write_n, writedata,
    input  readdata
  );

  modport slave (
    input  address, chipselect, read_n, write_n, writedata,
    output readdata
  );
endinterface

// File: rtl/nios2_system_gpio_pio.sv
// Parametrised Avalon-MM GPIO peripheral with direction control, atomic set/clear,
// synchronised inputs and maskable edge capture.
//   clk      : system clock, rising edge
//   reset    : asynchronous, active-high
//   bus      : Avalon-MM slave (latency-1 registered reads)
//   in_port  : asynchronous pin inputs
//   out_port : output data register
//   out_oe   : per-bit output enable (1 = output)
//   irq      : |(edgecapture & irqmask)
module nios2_system_gpio_pio #(
  parameter int unsigned           DATA_WIDTH  = 8,
  parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0,
  parameter int unsigned           EDGE_TYPE   = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  nios2_system_gpio_pio_if.slave bus,
  input  logic [DATA_WIDTH-1:0] in_port,
  output logic [DATA_WIDTH-1:0] out_port,
  output logic [DATA_WIDTH-1:0] out_oe,
  output logic                  irq
);

  logic [DATA_WIDTH-1:0] r_data_out, r_dir, r_mask, r_edge;
  logic [DATA_WIDTH-1:0] r_sync1, r_sync2, r_prev;
  logic [31:0]           r_readdata;
  logic [1:0]            r_warm;

  logic                  w_wr, w_rd, w_warm_done;
  logic [DATA_WIDTH-1:0] w_wdata, w_clr, w_edge_raw, w_edge_det;
  logic [DATA_WIDTH-1:0] w_data_out_d, w_dir_d, w_mask_d, w_edge_d, w_rmux;
  logic                  w_unused_wdata;

  assign w_wr    = bus.chipselect & ~bus.write_n;
  assign w_rd    = bus.chipselect & ~bus.read_n;
  assign w_wdata = bus.writedata[DATA_WIDTH-1:0];
  // Upper write-data bits are intentionally ignored.
  assign w_unused_wdata = ^bus.writedata;

  // Edge detect on the synchronised value; held off until the synchroniser
  // has flushed its reset state so pins high at reset release do not capture.
  always_comb begin
    w_edge_raw = r_sync2 ^ r_prev;
    if (EDGE_TYPE == 0)      w_edge_raw = r_sync2 & ~r_prev;
    else if (EDGE_TYPE == 1) w_edge_raw = ~r_sync2 & r_prev;
  end

  assign w_warm_done = (r_warm == 2'd3);
  assign w_edge_det  = w_warm_done ? w_edge_raw : '0;

  always_comb begin
    w_data_out_d = r_data_out;
    w_dir_d      = r_dir;
    w_mask_d     = r_mask;
    w_clr        = '0;
    if (w_wr) begin
      case (bus.address)
        3'd0:    w_data_out_d = w_wdata;
        3'd1:    w_dir_d      = w_wdata;
        3'd2:    w_mask_d     = w_wdata;
        3'd3:    w_clr        = w_wdata;
        3'd4:    w_data_out_d = r_data_out | w_wdata;
        3'd5:    w_data_out_d = r_data_out & ~w_wdata;
        default: ;
      endcase
    end
    // A new edge beats a simultaneous clear on the same bit.
    w_edge_d = (r_edge & ~w_clr) | w_edge_det;
  end

  // Read mux sees pre-write register values.
  always_comb begin
    w_rmux = '0;
    case (bus.address)
      3'd0:    w_rmux = (r_data_out & r_dir) | (r_sync2 & ~r_dir);
      3'd1:    w_rmux = r_dir;
      3'd2:    w_rmux = r_mask;
      3'd3:    w_rmux = r_edge;
      default: w_rmux = '0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_data_out <= RESET_VALUE;
      r_dir      <= '0;
      r_mask     <= '0;
      r_edge     <= '0;
      r_sync1    <= '0;
      r_sync2    <= '0;
      r_prev     <= '0;
      r_readdata <= '0;
      r_warm     <= '0;
    end else begin
      r_data_out <= w_data_out_d;
      r_dir      <= w_dir_d;
      r_mask     <= w_mask_d;
      r_edge     <= w_edge_d;
      r_sync1    <= in_port;
      r_sync2    <= r_sync1;
      r_prev     <= r_sync2;
      if (w_rd) r_readdata <= 32'(w_rmux);
      if (!w_warm_done) r_warm <= r_warm + 2'd1;
    end
  end

  assign bus.readdata = r_readdata;
  assign out_port     = r_data_out;
  assign out_oe       = r_dir;
  assign irq          = |(r_edge & r_mask);

endmodule
